// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D,
    ARB_RESP_I,
    ARB_RESP_D
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int   WD_W   = 8;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Per-access watchdog: counts GRANT cycles without a memory answer.
import mem_arb_pkg::*;

module mem_arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt;

  // TIMEOUT <= 255 keeps the count below the 8-bit ceiling, so no wrap guard.
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (tick)    cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between an instruction-fetch port and a data port,
// with round-robin or fixed data-priority grants and a per-access watchdog.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 32,
  parameter int DATA_PRIORITY = 0,
  parameter int TIMEOUT       = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_request,
  input  logic              i_we_re,
  input  logic [3:0]        i_mask,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              i_valid,
  output logic              i_err,
  output logic [DATA_W-1:0] i_data_out,
  input  logic              d_request,
  input  logic              d_we_re,
  input  logic [3:0]        d_mask,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_data_in,
  output logic              d_valid,
  output logic              d_err,
  output logic [DATA_W-1:0] d_data_out,
  output logic              m_request,
  output logic              m_we_re,
  output logic [3:0]        m_mask,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_data_in,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_data_out
);

  arb_state_e state, state_nxt;
  logic       last_grant;
  logic       grant, grant_port;
  logic       wd_tick, expired;
  logic       in_grant, done;

  assign in_grant = (state == ARB_GRANT_I) || (state == ARB_GRANT_D);
  // A same-cycle m_valid wins over expiry, so the last-chance answer is a success.
  assign done     = in_grant && (m_valid || expired);

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_port = PORT_I;
    wd_tick    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (i_request || d_request) begin
          grant = 1'b1;
          if (d_request && (!i_request || DATA_PRIORITY != 0 || last_grant == PORT_I))
            grant_port = PORT_D;
          state_nxt = (grant_port == PORT_D) ? ARB_GRANT_D : ARB_GRANT_I;
        end
      end
      ARB_GRANT_I: begin
        if (done) state_nxt = ARB_RESP_I;
        else      wd_tick   = 1'b1;
      end
      ARB_GRANT_D: begin
        if (done) state_nxt = ARB_RESP_D;
        else      wd_tick   = 1'b1;
      end
      ARB_RESP_I, ARB_RESP_D: state_nxt = ARB_IDLE;
      default:                state_nxt = ARB_IDLE;
    endcase
  end

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .tick    (wd_tick),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_I;
      m_request  <= 1'b0;
      m_we_re    <= 1'b0;
      m_mask     <= '0;
      m_address  <= '0;
      m_data_in  <= '0;
      i_valid    <= 1'b0;
      i_err      <= 1'b0;
      i_data_out <= '0;
      d_valid    <= 1'b0;
      d_err      <= 1'b0;
      d_data_out <= '0;
    end else begin
      i_valid <= 1'b0;
      i_err   <= 1'b0;
      d_valid <= 1'b0;
      d_err   <= 1'b0;
      if (grant) begin
        last_grant <= grant_port;
        m_request  <= 1'b1;
        m_we_re    <= (grant_port == PORT_D) ? d_we_re   : i_we_re;
        m_mask     <= (grant_port == PORT_D) ? d_mask    : i_mask;
        m_address  <= (grant_port == PORT_D) ? d_address : i_address;
        m_data_in  <= (grant_port == PORT_D) ? d_data_in : i_data_in;
      end else if (done) begin
        m_request <= 1'b0;
        if (state == ARB_GRANT_I) begin
          i_valid    <= 1'b1;
          i_err      <= !m_valid;
          i_data_out <= m_valid ? m_data_out : '0;
        end else begin
          d_valid    <= 1'b1;
          d_err      <= !m_valid;
          d_data_out <= m_valid ? m_data_out : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench: a round-robin and a data-priority arbiter, each checked
// every cycle against a transaction-level model of the access protocol.
module tb_mem_arbiter;

  localparam int TO     = 4;
  localparam int CYCLES = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, i_request, d_request, i_we_re, d_we_re;
  logic [1:0]       i_valid, d_valid, i_err, d_err, m_request, m_we_re, m_valid;
  logic [1:0][3:0]  i_mask, d_mask, m_mask;
  logic [1:0][7:0]  i_address, d_address, m_address;
  logic [1:0][31:0] i_data_in, d_data_in, i_data_out, d_data_out, m_data_in, m_data_out;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .DATA_PRIORITY(0), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst[0]),
    .i_request(i_request[0]), .i_we_re(i_we_re[0]), .i_mask(i_mask[0]),
    .i_address(i_address[0]), .i_data_in(i_data_in[0]),
    .i_valid(i_valid[0]), .i_err(i_err[0]), .i_data_out(i_data_out[0]),
    .d_request(d_request[0]), .d_we_re(d_we_re[0]), .d_mask(d_mask[0]),
    .d_address(d_address[0]), .d_data_in(d_data_in[0]),
    .d_valid(d_valid[0]), .d_err(d_err[0]), .d_data_out(d_data_out[0]),
    .m_request(m_request[0]), .m_we_re(m_we_re[0]), .m_mask(m_mask[0]),
    .m_address(m_address[0]), .m_data_in(m_data_in[0]),
    .m_valid(m_valid[0]), .m_data_out(m_data_out[0])
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .DATA_PRIORITY(1), .TIMEOUT(TO)) u_dp (
    .clk(clk), .rst(rst[1]),
    .i_request(i_request[1]), .i_we_re(i_we_re[1]), .i_mask(i_mask[1]),
    .i_address(i_address[1]), .i_data_in(i_data_in[1]),
    .i_valid(i_valid[1]), .i_err(i_err[1]), .i_data_out(i_data_out[1]),
    .d_request(d_request[1]), .d_we_re(d_we_re[1]), .d_mask(d_mask[1]),
    .d_address(d_address[1]), .d_data_in(d_data_in[1]),
    .d_valid(d_valid[1]), .d_err(d_err[1]), .d_data_out(d_data_out[1]),
    .m_request(m_request[1]), .m_we_re(m_we_re[1]), .m_mask(m_mask[1]),
    .m_address(m_address[1]), .m_data_in(m_data_in[1]),
    .m_valid(m_valid[1]), .m_data_out(m_data_out[1])
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  mask;
    logic [7:0]  addr;
    logic [31:0] data;
  } acc_t;

  // Model of one arbiter: the access in flight, its pending response, and
  // the expected sticky read-data per port.
  bit          busy[2], own[2], last[2], rsp[2], rsp_port[2], rsp_err[2];
  int          age[2], lat[2];
  acc_t        cur[2];
  logic [31:0] exp_do[2][2];

  int checks, failures;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic acc_t req_of(int n, bit p);
    acc_t a;
    a.we   = p ? d_we_re[n]    : i_we_re[n];
    a.mask = p ? d_mask[n]     : i_mask[n];
    a.addr = p ? d_address[n]  : i_address[n];
    a.data = p ? d_data_in[n]  : i_data_in[n];
    return a;
  endfunction

  task automatic drive_port(int n, bit p, bit on);
    if (p) begin
      d_request[n] = on;        d_we_re[n]   = 1'($urandom);
      d_mask[n]    = 4'($urandom); d_address[n] = 8'($urandom);
      d_data_in[n] = $urandom;
    end else begin
      i_request[n] = on;        i_we_re[n]   = 1'($urandom);
      i_mask[n]    = 4'($urandom); i_address[n] = 8'($urandom);
      i_data_in[n] = $urandom;
    end
  endtask

  task automatic model_reset(int n);
    busy[n] = 0; rsp[n] = 0; last[n] = 0; age[n] = 0; lat[n] = 0;
    cur[n] = '0; exp_do[n][0] = '0; exp_do[n][1] = '0;
  endtask

  task automatic step(int n, int cyc);
    string pf;
    bit    on, ir, dr;
    int    r;
    pf = (n == 0) ? "rr" : "dp";

    chk({pf, ".m_request"}, 32'(m_request[n]), 32'(busy[n]));
    chk({pf, ".m_ctrl"}, 32'({m_we_re[n], m_mask[n], m_address[n]}),
        32'({cur[n].we, cur[n].mask, cur[n].addr}));
    chk({pf, ".m_data_in"}, m_data_in[n], cur[n].data);
    chk({pf, ".i_valid"}, 32'(i_valid[n]), 32'(rsp[n] && !rsp_port[n]));
    chk({pf, ".d_valid"}, 32'(d_valid[n]), 32'(rsp[n] && rsp_port[n]));
    chk({pf, ".i_err"}, 32'(i_err[n]), 32'(rsp[n] && !rsp_port[n] && rsp_err[n]));
    chk({pf, ".d_err"}, 32'(d_err[n]), 32'(rsp[n] && rsp_port[n] && rsp_err[n]));
    chk({pf, ".i_data_out"}, i_data_out[n], exp_do[n][0]);
    chk({pf, ".d_data_out"}, d_data_out[n], exp_do[n][1]);

    // Reset: held through the first two edges, plus occasional aborts in
    // the 2nd GRANT cycle.
    rst[n] = (cyc == 0) || (busy[n] && age[n] == 1 && $urandom_range(0, 7) == 0);

    for (int p = 0; p < 2; p++) begin
      on = (p == 1) ? d_request[n] : i_request[n];
      if (cyc == 0) begin
      end else if (rsp[n] && rsp_port[n] == 1'(p))
        drive_port(n, 1'(p), $urandom_range(0, 1) == 1);
      else if (!on) begin
        if ($urandom_range(0, 2) == 0) drive_port(n, 1'(p), 1'b1);
      end else if (busy[n] && own[n] == 1'(p))
        drive_port(n, 1'(p), 1'b1);
    end

    if (busy[n]) m_valid[n] = (age[n] + 1 == lat[n]);
    else         m_valid[n] = ($urandom_range(0, 5) == 0);
    m_data_out[n] = $urandom;

    // Advance the model to the state after the coming edge.
    if (rst[n]) model_reset(n);
    else if (rsp[n]) rsp[n] = 0;
    else if (busy[n]) begin
      if (m_valid[n]) begin
        rsp[n] = 1; rsp_port[n] = own[n]; rsp_err[n] = 0; busy[n] = 0;
        exp_do[n][own[n]] = m_data_out[n];
      end else if (age[n] == TO - 1) begin
        rsp[n] = 1; rsp_port[n] = own[n]; rsp_err[n] = 1; busy[n] = 0;
        exp_do[n][own[n]] = '0;
      end else age[n]++;
    end else begin
      ir = i_request[n];
      dr = d_request[n];
      if (ir || dr) begin
        own[n]  = dr && (!ir || n == 1 || !last[n]);
        last[n] = own[n];
        busy[n] = 1;
        age[n]  = 0;
        cur[n]  = req_of(n, own[n]);
        r = $urandom_range(0, 9);
        lat[n] = (r < 5) ? 1 : (r == 5) ? 2 : (r == 6) ? 3 : (r == 7) ? TO : TO + 2;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 2'b11;
    m_valid = '0;
    m_data_out = '0;
    for (int n = 0; n < 2; n++) begin
      drive_port(n, 1'b0, 1'b1);
      drive_port(n, 1'b1, 1'b1);
      model_reset(n);
    end
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      step(0, cyc);
      step(1, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one `memory` instance between the core's instruction-fetch port and its data load/store port, enabling a unified instruction/data memory. It sits between `core` and a single `memory`. Requester-side and memory-side signals use the same request/valid handshake, so either side connects without glue. Grants are round-robin or fixed data-priority. A per-access watchdog keeps a stalled memory from hanging the core.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width, equal to the memory's `address` width.
- `DATA_W`, 32: data width.
- `DATA_PRIORITY`, 0: 0 selects round-robin; 1 gives the data port fixed priority.
- `TIMEOUT`, 15: maximum number of GRANT cycles without `m_valid` before the access aborts. Range is 1..255.

Ports:
- `clk` in 1: the single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `i_request`, `d_request` in 1: access request, held until the matching `*_valid`.
- `i_we_re`, `d_we_re` in 1: 1 means write, 0 means read.
- `i_mask`, `d_mask` in 4: byte enables.
- `i_address`, `d_address` in ADDR_W: word address.
- `i_data_in`, `d_data_in` in DATA_W: write data.
- `i_valid`, `d_valid` out 1: one-cycle completion pulse.
- `i_err`, `d_err` out 1: one-cycle timeout pulse, coincident with `*_valid`.
- `i_data_out`, `d_data_out` out DATA_W: read data, valid while `*_valid`=1.
- `m_request`, `m_we_re` out 1: to the memory.
- `m_mask` out 4; `m_address` out ADDR_W; `m_data_in` out DATA_W: to the memory.
- `m_valid` in 1; `m_data_out` in DATA_W: from the memory.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one request, grant it.
  - If both request: with `DATA_PRIORITY`=1, D wins. With `DATA_PRIORITY`=0, the port not in `last_grant` wins.
- On a grant:
  - Register the winner's `we_re`, `mask`, `address` and `data_in` into the `m_*` outputs.
  - Set `last_grant`.
  - Clear the watchdog counter.
- GRANT_x:
  - Hold `m_request`=1 and keep the `m_*` outputs stable.
  - If `m_valid` is 1, capture `m_data_out` into `x_data_out` and go to RESP_x.
  - Otherwise, if the counter equals `TIMEOUT`-1, go to RESP_x with `err` set.
  - Otherwise, increment the counter.
- RESP_x:
  - `x_valid`=1 for exactly one cycle; `x_err` reflects the timeout flag.
  - `m_request`=0.
  - Next state is always IDLE, so the requester has a cycle to drop `request`.
- Requester inputs are sampled only in IDLE. Changes during GRANT or RESP are ignored.
- `x_data_out` holds its last value outside RESP.
  - On a write it carries the captured `m_data_out`; the requester ignores it.
  - On a timeout it is 0.
- The non-granted port sees `valid`=0 and `err`=0 throughout.
- `m_valid` arriving in IDLE or RESP is ignored.

## Timing
- Reset (`rst`=1 at an edge):
  - State becomes IDLE; `last_grant` becomes I, so D wins the first tie under round-robin.
  - All outputs become 0, including `m_*`, `*_valid`, `*_err` and `*_data_out`.
  - The counter becomes 0.
  - Requests present while `rst`=1 are ignored.
- Reset mid-GRANT: `m_request` drops on the next edge, no response is issued, and the requester must re-request.
- Latency: request seen in IDLE at edge N, then `m_request`=1 from N+1.
- If the memory answers `m_valid` in its k-th GRANT cycle (k≥1), `x_valid` is high during cycle N+k+1.
- Minimum access is 3 cycles (IDLE, GRANT, RESP). Back-to-back accesses are 3 cycles apart when the memory answers in 1.
- Timeout: `TIMEOUT` GRANT cycles without `m_valid`, then RESP with `err`=1.
- If `m_valid` arrives in the same cycle the counter reaches `TIMEOUT`-1, it counts as success and `err`=0.
- The counter is 8 bits and never wraps, because `TIMEOUT`≤255.

## Structure
- Shared package `mem_arb_pkg`:
  - State encoding: `ARB_IDLE`, `ARB_GRANT_I`, `ARB_GRANT_D`, `ARB_RESP_I`, `ARB_RESP_D`.
  - Port-ID constants `PORT_I`=0 and `PORT_D`=1.
- Natural sub-module: `mem_arb_watchdog`. It contains the counter with `clear`/`tick` inputs and an `expired` output.
- The FSM, `m_*` registers and response registers stay in `mem_arbiter`.

## Test plan
- Reset: `rst`=1 for 2 cycles while `i_request`=`d_request`=1 → all outputs 0 throughout. After release, D is granted first (round-robin).
- Single read:
  - Stimulus: `i_request`=1, `i_address`=8'h04; memory returns `m_valid` 1 cycle after `m_request` with `m_data_out`=32'h00500093.
  - Required: `m_address`=8'h04 and `m_we_re`=0; `i_valid`=1 with `i_data_out`=32'h00500093 exactly 3 cycles after the request is sampled; `d_valid` stays 0.
- Contention, round-robin: both ports request continuously for 4 accesses → grants alternate D, I, D, I. Each response arrives on its own port only.
- Contention, `DATA_PRIORITY`=1: both request and D re-requests immediately → D is granted every time and I is not served until D idles.
- Write masking: `d_we_re`=1, `d_mask`=4'b0011, `d_address`=8'h10, `d_data_in`=32'hDEADBEEF → the `m_*` outputs carry exactly these values, held stable until `m_valid`.
- Timeout and reset abort:
  - With `TIMEOUT`=4 and `m_valid` never asserted: `d_valid`=`d_err`=1 after 4 GRANT cycles, and `d_data_out`=0.
  - A repeat where `rst` is asserted in the 2nd GRANT cycle: no `d_valid`, and `m_request`=0 on the next edge.
